serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around one full-adder cell and a carry flip-flop.
//   - Sequences operand bits LSB-first into the cell, one bit per clock.
//   - Collects the sum bits into a shift register.
//   - Presents the result with a one-cycle done pulse.
//   Replaces a WIDTH-wide ripple array where area matters more than latency.
// PARAMETERS
//   WIDTH  8  operand and result width in bits; legal range is WIDTH >= 2
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request; sampled only while idle (busy=0)
//   a_in     in   WIDTH  operand A; captured on the accepted start edge
//   b_in     in   WIDTH  operand B; captured on the accepted start edge
//   cin      in   1      carry-in; captured on the accepted start edge
//   busy     out  1      high while an addition is in progress
//   done     out  1      one-cycle pulse: sum_out/cout just updated
//   sum_out  out  WIDTH  result register; held until the next done
//   cout     out  1      final carry; held until the next done
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - state=IDLE; busy=0, done=0, sum_out=0, cout=0.
//     - Internal shift registers, carry FF and bit counter are cleared.
//   - FSM states:
//     - IDLE: busy=0. On a rising edge with start=1:
//       - a_sr<=a_in, b_sr<=b_in, c_ff<=cin, cnt<=0, sum_sr<=0.
//       - Next state is SHIFT; busy=1 from this edge.
//     - SHIFT: each edge runs full-adder s,co = f(a_sr[0], b_sr[0], c_ff):
//       - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
//       - a_sr and b_sr shift right by 1 (zero fill).
//       - c_ff<=co, cnt<=cnt+1.
//     - SHIFT exit, on the edge where cnt==WIDTH-1:
//       - sum_out <= {s, sum_sr[WIDTH-1:1]}, cout<=co.
//       - done<=1, busy<=0, state<=IDLE.
//   - done is high for exactly one cycle; it is cleared on the next edge.
//   - Latency: start accepted at edge k; done and result are visible after edge k+WIDTH.
//   - Throughput: one addition per WIDTH+1 cycles.
//   - Back-to-back: start=1 in the done cycle is accepted (state is already IDLE).
//   - start=1 while busy=1 is ignored; the in-flight operands are unaffected.
//   - Operand inputs are don't-care except on the accepted start edge.
//   - Result is sum mod 2^WIDTH; cout is bit WIDTH of a+b+cin.
//   - cnt is $clog2(WIDTH) bits wide and never wraps during a valid run.
//   - rst_n low mid-SHIFT aborts the operation:
//     - No done pulse; sum_out/cout are cleared.
//     - The next start after release behaves normally.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined:
//     - Adds input port sub (1 bit), captured with the operands.
//     - sub=1: b_sr loads ~b_in and c_ff loads 1 (cin ignored); result = a-b mod 2^WIDTH.
//       - cout=1 means no borrow (a >= b unsigned).
//     - sub=0: identical to the add path.
//   SERIAL_ADDER_SUB_EN undefined:
//     - No sub port; add only; the cin path is unconditional.
// TESTING (WIDTH=8 unless noted)
//   1. a=0x00, b=0x00, cin=0, start 1 cycle -> busy 8 cycles; done 1 cycle; sum_out=0x00, cout=0.
//   2. a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1; a=0x5A, b=0xA5, cin=1 -> sum_out=0x00, cout=1.
//   3. start pulsed with a=0x11, b=0x22 mid-run of a=0x03, b=0x04 -> done once, sum_out=0x07;
//      next start taken in the done cycle -> second done 9 cycles later.
//   4. rst_n=0 for 1 cycle at shift bit 3 of a=0xF0, b=0x0F -> busy=0 and done=0 at once;
//      sum_out=0, no done follows; a fresh start then gives sum_out=0xFF, cout=0.
//   5. WIDTH=3 exhaustive: all 128 (a,b,cin) -> {cout,sum_out} == a+b+cin;
//      done count equals start count.
//   6. SERIAL_ADDER_SUB_EN, sub=1: a=0x10, b=0x01 -> 0x0F, cout=1; a=0x01, b=0x02 -> 0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell
// and a carry flip-flop. Operands are consumed LSB-first, one bit per clock.
// The sum bits are collected in a shift register. The result is published
// together with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input is added. With sub=1 the adder computes
//   a - b mod 2^WIDTH by loading ~b and forcing the carry-in to 1.
//   In that mode cout=1 means no borrow occurred.
//
// State table:
//   state   | meaning
//   S_IDLE  | waiting for start; operands are captured on the accepted edge
//   S_SHIFT | one full-adder step per clock; exits after WIDTH steps
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_c_ff;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // The single full-adder cell that every bit position shares.
  assign w_s  = r_a_sr[0] ^ r_b_sr[0] ^ r_c_ff;
  assign w_co = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_c_ff) | (r_b_sr[0] & r_c_ff);

  assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is two's-complement addition: invert b and add 1.
  assign w_b_load = sub ? ~b_in : b_in;
  assign w_c_load = sub ? 1'b1  : cin;
`else
  assign w_b_load = b_in;
  assign w_c_load = cin;
`endif

  // Sequencing FSM: it owns the datapath registers and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_c_ff   <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr   <= a_in;
            r_b_sr   <= w_b_load;
            r_c_ff   <= w_c_load;
            r_cnt    <= '0;
            r_sum_sr <= '0;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sum_sr <= w_sum_next;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_c_ff   <= w_co;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            sum_out <= w_sum_next;
            cout    <= w_co;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder. It drives two instances: WIDTH=8 for directed
// vectors and WIDTH=3 for an exhaustive sweep. Expected results are queued
// when a start is driven while the DUT is idle. They are popped and compared
// when done is seen.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3;
  logic [2:0] a3 = '0, b3 = '0, sum3;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8 = 1'b0;
  logic       sub3 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int dones8 = 0;
  int dones3 = 0;
  int starts3 = 0;

  logic [8:0] q8[$];
  logic [3:0] q3[$];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a3), .b_in(b3), .cin(cin3),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub3),
`endif
    .busy(busy3), .done(done3), .sum_out(sum3), .cout(cout3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard pop for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      dones8++;
      chk("q8_nonempty_on_done", (q8.size() != 0), 1);
      if (q8.size() != 0) chk("result8", {cout8, sum8}, q8.pop_front());
    end
  end

  // Scoreboard pop for the 3-bit instance.
  always @(negedge clk) begin
    if (done3) begin
      dones3++;
      chk("q3_nonempty_on_done", (q3.size() != 0), 1);
      if (q3.size() != 0) chk("result3", {cout3, sum3}, q3.pop_front());
    end
  end

  // Call at a negedge: drives start for one cycle and returns at the negedge where done is seen.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp, output int lat, output int bcnt);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    if (!busy8) q8.push_back(exp);
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      if (busy8) bcnt++;
    end while (!done8 && lat < 40);
  endtask

  task automatic do_op3(input logic [2:0] a, input logic [2:0] b, input logic c,
                        input logic [3:0] exp, output int lat);
    a3 = a; b3 = b; cin3 = c; start3 = 1'b1;
    if (!busy3) begin
      q3.push_back(exp);
      starts3++;
    end
    lat = 0;
    do begin
      @(negedge clk);
      start3 = 1'b0;
      lat++;
    end while (!done3 && lat < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, d;
    logic [3:0] e3;

    vecs[0] = '{a:8'h00, b:8'h00, cin:1'b0, s:8'h00, co:1'b0};
    vecs[1] = '{a:8'hFF, b:8'h01, cin:1'b0, s:8'h00, co:1'b1};
    vecs[2] = '{a:8'h5A, b:8'hA5, cin:1'b1, s:8'h00, co:1'b1};
    vecs[3] = '{a:8'h03, b:8'h04, cin:1'b0, s:8'h07, co:1'b0};
    vecs[4] = '{a:8'h80, b:8'h80, cin:1'b0, s:8'h00, co:1'b1};
    vecs[5] = '{a:8'h7F, b:8'h01, cin:1'b1, s:8'h81, co:1'b0};
    vecs[6] = '{a:8'hAA, b:8'h55, cin:1'b0, s:8'hFF, co:1'b0};
    vecs[7] = '{a:8'hFF, b:8'hFF, cin:1'b1, s:8'hFF, co:1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors: latency, busy length and one-cycle done.
    for (int i = 0; i < 8; i++) begin
      do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].co, vecs[i].s}, lat, bcnt);
      chk($sformatf("lat_vec%0d", i), lat, 9);
      chk($sformatf("busy_len_vec%0d", i), bcnt, 8);
      @(negedge clk);
      chk($sformatf("done_pulse_vec%0d", i), done8, 0);
    end

    // A start raised mid-run is ignored; then a back-to-back start in the done cycle.
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h007);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    chk("busy_mid_run", busy8, 1);
    @(negedge clk); start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ignored_start_done_seen", done8, 1);
    do_op8(8'h11, 8'h22, 1'b0, 9'h033, lat, bcnt);
    chk("back_to_back_lat", lat, 9);

    // Reset asserted mid-shift aborts the operation.
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d = dones8;
    repeat (12) @(negedge clk);
    chk("abort_no_done", dones8, d);
    do_op8(8'hF0, 8'h0F, 1'b0, 9'h0FF, lat, bcnt);
    chk("after_abort_lat", lat, 9);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract mode; cin is deliberately set to 0 to show that it is ignored.
    @(negedge clk);
    sub8 = 1'b1;
    do_op8(8'h10, 8'h01, 1'b0, 9'h10F, lat, bcnt);
    chk("sub1_lat", lat, 9);
    @(negedge clk);
    do_op8(8'h01, 8'h02, 1'b0, 9'h0FF, lat, bcnt);
    chk("sub2_lat", lat, 9);
    @(negedge clk);
    sub8 = 1'b0;
    do_op8(8'h01, 8'h02, 1'b1, 9'h004, lat, bcnt);
    chk("sub0_lat", lat, 9);
`endif

    // WIDTH=3 exhaustive sweep, using back-to-back starts in each done cycle.
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          e3 = 4'(a + b + c);
          do_op3(3'(a), 3'(b), c[0], e3, lat);
          if (lat != 4) chk($sformatf("lat3_%0d_%0d_%0d", a, b, c), lat, 4);
        end
      end
    end
    @(negedge clk);
    chk("w3_starts", starts3, 128);
    chk("w3_done_count", dones3, starts3);
    chk("q8_drained", q8.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
